dbg_tx_ser: RTL and testbench
=============================

Name: dbg_tx_ser

Overview:
- Downstream serializer for the debug controller's tapped data.
- The controller hands over a 16-bit captured word (e.g. the UTAP_PC program counter) via a valid/ready handshake; this block frames it and shifts it out on the board-facing dbg_tx line.
- Frame: start bit, data MSB-first, stop bit. Bit period set by a clock divider.

Parameters:
- DATA_W, 16: payload width in bits; must be >= 1.
- CLKS_PER_BIT, 4: clk cycles each serial bit is held; must be >= 1.
- CNT_W, 8: width of the bit-period and bit-index counters; must hold max(CLKS_PER_BIT-1, DATA_W-1).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_W  word to send; sampled only on acceptance.
- tx_valid  input  1  upstream has a word.
- tx_ready  output  1  block can accept a word; high only in IDLE.
- dbg_tx  output  1  serial line to the board RX; idles high.
- busy  output  1  high while a frame is in progress (not IDLE).
- done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; dbg_tx=1; tx_ready=1; busy=0; done=0; shift register and counters cleared.
  - Reset mid-frame aborts immediately: dbg_tx returns to 1 asynchronously and no done pulse is produced.
- FSM states: IDLE, START, DATA, [PARITY], STOP. All outputs are registered or decoded from registered state only.
- Acceptance:
  - Occurs when tx_valid && tx_ready at a posedge.
  - tx_data is latched into the shift register; state goes to START; the bit timer is loaded with CLKS_PER_BIT-1.
  - dbg_tx=0 is visible the cycle after acceptance (latency 1).
- Bit timer:
  - Counts down from CLKS_PER_BIT-1.
  - On reaching 0 with tick, advances to the next bit and reloads.
  - Each bit is held exactly CLKS_PER_BIT cycles; with CLKS_PER_BIT=1, one cycle per bit.
- START: on tick, goes to DATA with bit index = DATA_W-1.
- DATA:
  - dbg_tx = shift_reg[DATA_W-1]. On each tick, shift left by one and decrement the index.
  - When index=0 and tick, go to STOP (or PARITY if enabled).
- STOP: dbg_tx=1. On tick, go to IDLE and pulse done for exactly that one cycle.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles, i.e. 72 cycles at defaults.
- Back-to-back:
  - tx_ready is low during START..STOP.
  - IDLE lasts at least one cycle, so the minimum gap between frames is one cycle of dbg_tx=1.
  - tx_valid held high is accepted on the first IDLE cycle.
  - tx_valid or tx_data changes while busy are ignored; no buffering.
- The payload is transmitted exactly as latched. All counters are unsigned and wrap is never reached under legal parameters.

Optional Feature:
- Macro: DBG_TX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP.
  - dbg_tx = XOR of all DATA_W latched bits (even parity), held CLKS_PER_BIT cycles.
  - Parity is computed at acceptance time and stored in a register.
  - Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- When undefined: no PARITY state or register exists, and DATA goes directly to STOP.

Decomposition:
- Package dbg_pkg contains:
  - DBG_WORD_W=16.
  - UTAP select constants (UTAP_PC=16'h01).
  - The dbg_tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
- The package is shared with the debug controller.
- One sub-module, dbg_bit_timer:
  - Reloadable down-counter with a tick output.
  - Parameterised by CLKS_PER_BIT and CNT_W.
  - Reusable for the receive side later.

Test Plan:
- Reset, then idle 10 cycles -> dbg_tx=1, tx_ready=1, busy=0, done=0 throughout.
- Send tx_data=16'hA5C3 at defaults:
  - dbg_tx low for 4 cycles starting one cycle after acceptance.
  - Then bits 1010_0101_1100_0011 MSB-first, 4 cycles each.
  - Then high 4 cycles.
  - done pulses once, 72 cycles after acceptance; tx_ready is low throughout.
- tx_valid held high with 16'h0001 then 16'hFFFF:
  - Second frame's start bit begins exactly one idle-high cycle after the first done.
  - Changes to tx_data mid-frame do not alter the first frame.
- Assert rst_n=0 during DATA bit 7 of 16'h1234 -> dbg_tx=1 immediately, no done pulse. After release, tx_ready=1 and a new frame of 16'h00FF transmits cleanly.
- CLKS_PER_BIT=1, tx_data=16'h8001 -> 18-cycle frame: 0, 1, fourteen 0s, 1, 1.
- With DBG_TX_PARITY_EN:
  - tx_data=16'h0007 -> parity bit 1 before stop; frame length 76 cycles.
  - tx_data=16'h0003 -> parity bit 0.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared debug-controller definitions: word width, UTAP select codes
// and the serializer state encoding.
package dbg_pkg;

    localparam int DBG_WORD_W = 16;

    // UTAP tap-select codes understood by the debug controller.
    localparam logic [15:0] UTAP_NONE  = 16'h0000;
    localparam logic [15:0] UTAP_PC    = 16'h0001;
    localparam logic [15:0] UTAP_INSTR = 16'h0002;
    localparam logic [15:0] UTAP_ADDR  = 16'h0003;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } dbg_tx_state_t;

endpackage

// File: rtl/dbg_bit_timer.sv
// Reloadable bit-period down-counter; tick marks the last clock of a bit.
// Shared between the debug transmit and (future) receive paths.
module dbg_bit_timer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count down while running; reload on load or after the final clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= RELOAD;
        end else if (run) begin
            if (cnt_q == '0) begin
                cnt_q <= RELOAD;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Tick depends only on the registered count and the caller's run flag.
    always_comb begin
        tick = run && (cnt_q == '0);
    end

endmodule

// File: rtl/dbg_tx_ser.sv
// Debug word serializer: start bit, data MSB-first, stop bit on dbg_tx.
// Define DBG_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module dbg_tx_ser
    import dbg_pkg::*;
#(
    parameter int DATA_W       = DBG_WORD_W,
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dbg_tx,
    output logic              busy,
    output logic              done
);

    dbg_tx_state_t     state_q;
    dbg_tx_state_t     state_d;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  idx_q;
    logic              done_q;
    logic              accept;
    logic              run;
    logic              tick;
`ifdef DBG_TX_PARITY_EN
    logic              par_q;
`endif

    // Handshake and timer enables decoded from registered state.
    always_comb begin
        accept = tx_valid && (state_q == IDLE);
        run    = (state_q != IDLE);
    end

    dbg_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (accept),
        .run  (run),
        .tick (tick)
    );

    // State register; async reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: each non-idle state advances on the bit-timer tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick && (idx_q == '0)) begin
`ifdef DBG_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
            PARITY: begin
`ifdef DBG_TX_PARITY_EN
                if (tick) begin
                    state_d = STOP;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload shift register and bit index; word latched on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (accept) begin
            shift_q <= tx_data;
            idx_q   <= '0;
        end else if ((state_q == START) && tick) begin
            idx_q   <= CNT_W'(DATA_W - 1);
        end else if ((state_q == DATA) && tick) begin
            shift_q <= shift_q << 1;
            if (idx_q != '0) begin
                idx_q <= idx_q - 1'b1;
            end
        end
    end

`ifdef DBG_TX_PARITY_EN
    // Even parity of the word, captured once at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^tx_data;
        end
    end
`endif

    // Completion pulse lands on the first IDLE cycle after the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == STOP) && tick;
        end
    end

    // Outputs decoded from registered state only; line idles high.
    always_comb begin
        dbg_tx   = 1'b1;
        tx_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
        done     = done_q;
        unique case (state_q)
            IDLE:   dbg_tx = 1'b1;
            START:  dbg_tx = 1'b0;
            DATA:   dbg_tx = shift_q[DATA_W-1];
`ifdef DBG_TX_PARITY_EN
            PARITY: dbg_tx = par_q;
`else
            PARITY: dbg_tx = 1'b1;
`endif
            STOP:   dbg_tx = 1'b1;
            default: dbg_tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_dbg_tx_ser.sv
// Bench for dbg_tx_ser: frame scoreboard at CLKS_PER_BIT=4 plus a
// second instance at CLKS_PER_BIT=1. Honors DBG_TX_PARITY_EN.
module tb_dbg_tx_ser;

    localparam int DW  = 16;
    localparam int CPB = 4;
`ifdef DBG_TX_PARITY_EN
    localparam int NB  = DW + 3;
`else
    localparam int NB  = DW + 2;
`endif
    localparam int FL  = NB * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          dbg_tx;
    logic          busy;
    logic          done;

    logic [DW-1:0] t1_data = '0;
    logic          t1_valid = 1'b0;
    logic          t1_ready;
    logic          t1_tx;
    logic          t1_busy;
    logic          t1_done;

    always #5 clk = ~clk;

    dbg_tx_ser #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .dbg_tx(dbg_tx), .busy(busy), .done(done)
    );

    dbg_tx_ser #(.DATA_W(DW), .CLKS_PER_BIT(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(t1_data), .tx_valid(t1_valid),
        .tx_ready(t1_ready), .dbg_tx(t1_tx), .busy(t1_busy), .done(t1_done)
    );

    typedef struct {
        logic tx;
        logic dn;
        logic rdy;
        logic bsy;
    } exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
        int            len;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    logic nxt_par = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Model: expected per-cycle line levels for one accepted word.
    function automatic void push_frame(input logic [DW-1:0] d, input logic p);
        logic lv[$];
        exp_t e;
        lv.push_back(1'b0);
        for (int i = DW - 1; i >= 0; i--) lv.push_back(d[i]);
`ifdef DBG_TX_PARITY_EN
        lv.push_back(p);
`else
        if (p) begin end
`endif
        lv.push_back(1'b1);
        foreach (lv[k]) begin
            for (int c = 0; c < CPB; c++) begin
                e.tx = lv[k]; e.dn = 1'b0; e.rdy = 1'b0; e.bsy = 1'b1;
                sb.push_back(e);
            end
        end
        e.tx = 1'b1; e.dn = 1'b1; e.rdy = 1'b1; e.bsy = 1'b0;
        sb.push_back(e);
    endfunction

    // Acceptance observer: push expected frame when the handshake fires.
    always @(posedge clk) begin
        if (rst_n && tx_valid && tx_ready) push_frame(tx_data, nxt_par);
    end

    // Monitor: compare one scoreboard entry per cycle, count done pulses.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("sb_tx", 32'(dbg_tx), 32'(mon_e.tx));
            chk("sb_done", 32'(done), 32'(mon_e.dn));
            chk("sb_ready", 32'(tx_ready), 32'(mon_e.rdy));
            chk("sb_busy", 32'(busy), 32'(mon_e.bsy));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(tx_ready), 32'd1);
    endtask

    // Count cycles from acceptance to the done pulse (bounded).
    task automatic wait_done(input int len, input string nm);
        int n = 1;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(n - 1), 32'(len));
    endtask

    task automatic send(input logic [DW-1:0] d, input logic p, input int len);
        @(negedge clk);
        nxt_par  = p;
        tx_data  = d;
        tx_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = DW'($urandom);
        wait_done(len, "frame_len");
        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    vec_t vt[6];
    logic [NB-1:0] exp1;
    int d0;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{16'hA5C3, 1'b0, FL};
        vt[1] = '{16'h00FF, 1'b0, FL};
        vt[2] = '{16'h0007, 1'b1, FL};
        vt[3] = '{16'h0003, 1'b0, FL};
        vt[4] = '{16'h8001, 1'b0, FL};
        vt[5] = '{16'h0000, 1'b0, FL};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_tx", 32'(dbg_tx), 32'd1);
            chk("idle_ready", 32'(tx_ready), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
        end

        for (int i = 0; i < 6; i++) begin
            send(vt[i].data, vt[i].par, vt[i].len);
        end

        // Back-to-back with tx_valid held; data change mid-frame ignored.
        d0 = done_cnt;
        @(negedge clk);
        nxt_par  = 1'b1;
        tx_data  = 16'h0001;
        tx_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        repeat (20) @(negedge clk);
        tx_data = 16'hFFFF;
        nxt_par = 1'b0;
        wait_done(FL - 19, "b2b_len1");
        @(negedge clk);
        chk("b2b_start", 32'(dbg_tx), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        tx_valid = 1'b0;
        wait_done(FL, "b2b_len2");
        @(negedge clk);
        chk("b2b_dones", 32'(done_cnt - d0), 32'd2);
        chk("b2b_drain", 32'(sb.size()), 32'd0);

        // Reset during DATA bit 7 of 16'h1234.
        @(negedge clk);
        nxt_par  = 1'b1;
        tx_data  = 16'h1234;
        tx_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (37) @(negedge clk);
        #2;
        chk("pre_rst_tx", 32'(dbg_tx), 32'd0);
        d0 = done_cnt;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_tx", 32'(dbg_tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt), 32'(d0));
        chk("rst_ready", 32'(tx_ready), 32'd1);
        send(16'h00FF, 1'b0, FL);

        // CLKS_PER_BIT=1 instance, word 16'h8001.
`ifdef DBG_TX_PARITY_EN
        exp1 = 19'b010_0000_0000_0000_0101;
`else
        exp1 = 18'b01_0000_0000_0000_0011;
`endif
        @(negedge clk);
        t1_data  = 16'h8001;
        t1_valid = 1'b1;
        chk("c1_ready", 32'(t1_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        t1_valid = 1'b0;
        t1_data  = 16'h7FFE;
        for (int i = 0; i < NB; i++) begin
            chk("c1_tx", 32'(t1_tx), 32'(exp1[NB-1-i]));
            chk("c1_busy", 32'(t1_busy), 32'd1);
            chk("c1_done_lo", 32'(t1_done), 32'd0);
            @(negedge clk);
        end
        chk("c1_done", 32'(t1_done), 32'd1);
        chk("c1_idle", 32'(t1_busy), 32'd0);
        chk("c1_line", 32'(t1_tx), 32'd1);
        @(negedge clk);
        chk("c1_done_once", 32'(t1_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
